// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and register offsets for the UART MMIO block
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uartState_e;

   // Word offsets taken from dataAddr[3:2]; offset 3 is reserved.
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with same-edge push/pop and occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             doPush;
   logic             doPop;

   // A pop on the same edge frees a slot, so a full FIFO still accepts that push.
   assign doPop   = pop && !empty;
   assign doPush  = push && (!full || doPop);
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign popData = mem[rdPtr];

   // Pointer and count bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care after reset because the pointers are cleared.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped UART transmitter with TX FIFO and status/control registers
module uart_mmio
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dataAddr,
   input  logic [31:0] writeData,
   input  logic        we,
   output logic [31:0] readData,
   output logic        sel,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LOAD = 16'(CLKS_PER_BIT - 1);

   uartState_e     state, stateNext;
   logic [15:0]    baudCnt, baudNext;
   logic [2:0]     bitIdx, bitNext;
   logic [7:0]     shiftReg, shiftNext;
   logic           txNext;
   logic           overflow;
   logic           popReq;
   logic [1:0]     offset;
   logic           pushReq;
   logic           ctrlWr;
   logic           busy;
   logic [7:0]     headData;
   logic           fifoFull;
   logic           fifoEmpty;
   logic [CW-1:0]  fifoCount;
   logic [2:0]     idxPlusOne;
   logic           unusedBits;

   assign sel        = (dataAddr[31:4] == BASE_ADDR[31:4]);
   assign offset     = dataAddr[3:2];
   assign pushReq    = sel && we && (offset == REG_TXDATA);
   assign ctrlWr     = sel && we && (offset == REG_CTRL);
   assign busy       = (state != IDLE);
   assign idxPlusOne = bitIdx + 3'd1;
   assign unusedBits = ^{writeData[31:8], dataAddr[1:0]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) txFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (pushReq),
      .pushData (writeData[7:0]),
      .pop      (popReq),
      .popData  (headData),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   // Frame state register; tx is registered so the line never glitches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= stateNext;
         baudCnt  <= baudNext;
         bitIdx   <= bitNext;
         shiftReg <= shiftNext;
         tx       <= txNext;
      end
   end

   // Next-state logic; tx is computed for the state being entered so it changes with the state.
   always_comb begin
      stateNext = state;
      baudNext  = baudCnt;
      bitNext   = bitIdx;
      shiftNext = shiftReg;
      txNext    = tx;
      popReq    = 1'b0;
      case (state)
         IDLE: begin
            txNext = 1'b1;
            if (!fifoEmpty) begin
               popReq    = 1'b1;
               shiftNext = headData;
               baudNext  = BAUD_LOAD;
               stateNext = START;
               txNext    = 1'b0;
            end
         end
         START: begin
            if (baudCnt == '0) begin
               stateNext = DATA;
               bitNext   = 3'd0;
               baudNext  = BAUD_LOAD;
               txNext    = shiftReg[0];
            end else begin
               baudNext = baudCnt - 16'd1;
            end
         end
         DATA: begin
            if (baudCnt == '0) begin
               baudNext = BAUD_LOAD;
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
                  txNext    = 1'b1;
               end else begin
                  bitNext = idxPlusOne;
                  txNext  = shiftReg[idxPlusOne];
               end
            end else begin
               baudNext = baudCnt - 16'd1;
            end
         end
         STOP: begin
            if (baudCnt == '0) begin
               stateNext = IDLE;
               txNext    = 1'b1;
            end else begin
               baudNext = baudCnt - 16'd1;
            end
         end
         default: begin
            stateNext = IDLE;
            txNext    = 1'b1;
         end
      endcase
   end

   // Sticky overflow: set when a push is dropped, cleared by writing 1 to CTRL bit 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (ctrlWr && writeData[0]) begin
         overflow <= 1'b0;
      end else if (pushReq && fifoFull && !popReq) begin
         overflow <= 1'b1;
      end
   end

   // Combinational load path so a single-cycle CPU load sees data in the same cycle.
   always_comb begin
      readData = '0;
      if (sel) begin
         case (offset)
            REG_STATUS: readData = {23'd0, 5'(fifoCount), overflow, busy, fifoEmpty, fifoFull};
            default:    readData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - self-checking bench for uart_mmio with frame scoreboard
module tb_uart_mmio;

   localparam int          CPB  = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dataAddr = '0;
   logic [31:0] writeData = '0;
   logic        we = 1'b0;
   logic [31:0] readData;
   logic        sel;
   logic        tx;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [7:0] expQ[$];
   int         startQ[$];

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wd;
      logic        expSel;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecs[12];

   uart_mmio #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .dataAddr  (dataAddr),
      .writeData (writeData),
      .we        (we),
      .readData  (readData),
      .sel       (sel),
      .tx        (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
      dataAddr  = a;
      writeData = d;
      we        = 1'b1;
      tick();
      we        = 1'b0;
      dataAddr  = BASE + 32'd4;
   endtask

   task automatic statusNow(output logic [31:0] v);
      dataAddr = BASE + 32'd4;
      #1;
      v = readData;
   endtask

   task automatic waitIdle(input int limit);
      logic done;
      done = 1'b0;
      dataAddr = BASE + 32'd4;
      for (int i = 0; i < limit && !done; i++) begin
         #1;
         if (readData[1] && !readData[2]) done = 1'b1;
         else tick();
      end
      check("idle reached within bound", {31'd0, done}, 32'd1);
   endtask

   // Serial receiver: decodes frames on tx and compares each byte with the scoreboard.
   initial begin : monitor
      logic       prevTx;
      logic       active;
      int         cnt;
      logic [7:0] rx;
      logic [7:0] exp;
      prevTx = 1'b1;
      active = 1'b0;
      cnt    = 0;
      rx     = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            active = 1'b0;
         end else if (!active) begin
            if (prevTx && !tx) begin
               active = 1'b1;
               cnt    = 0;
               startQ.push_back(cyc);
            end
         end else begin
            cnt++;
            if (cnt == 2) check("mon start bit", {31'd0, tx}, 32'd0);
            if (cnt >= 6 && cnt <= 34 && ((cnt - 6) % 4) == 0) rx[(cnt - 6) / 4] = tx;
            if (cnt == 38) begin
               check("mon stop bit", {31'd0, tx}, 32'd1);
               if (expQ.size() == 0) begin
                  check("mon unexpected frame", {24'd0, rx}, 32'hFFFF_FFFF);
               end else begin
                  exp = expQ.pop_front();
                  check("mon frame byte", {24'd0, rx}, {24'd0, exp});
               end
               active = 1'b0;
            end
         end
         prevTx = tx;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] st;
      logic        seq [40];
      logic [7:0]  frameByte;
      int          lowCount;

      vecs[0]  = '{BASE + 32'd4,  1'b0, 32'h0,  1'b1, 32'h2};
      vecs[1]  = '{BASE + 32'd16, 1'b0, 32'h0,  1'b0, 32'h0};
      vecs[2]  = '{BASE + 32'd0,  1'b0, 32'h0,  1'b1, 32'h0};
      vecs[3]  = '{BASE + 32'd8,  1'b0, 32'h0,  1'b1, 32'h0};
      vecs[4]  = '{BASE + 32'd12, 1'b0, 32'h0,  1'b1, 32'h0};
      vecs[5]  = '{BASE + 32'd12, 1'b1, 32'hFF, 1'b1, 32'h0};
      vecs[6]  = '{BASE + 32'd4,  1'b0, 32'h0,  1'b1, 32'h2};
      vecs[7]  = '{BASE + 32'd7,  1'b0, 32'h0,  1'b1, 32'h2};
      vecs[8]  = '{32'h0002_0004, 1'b1, 32'h11, 1'b0, 32'h0};
      vecs[9]  = '{32'h0000_FFFC, 1'b1, 32'h22, 1'b0, 32'h0};
      vecs[10] = '{BASE + 32'd4,  1'b1, 32'hFF, 1'b1, 32'h2};
      vecs[11] = '{BASE + 32'd4,  1'b0, 32'h0,  1'b1, 32'h2};

      // Reset with a simultaneous TXDATA store that must be discarded.
      reset     = 1'b1;
      dataAddr  = BASE;
      writeData = 32'h5A;
      we        = 1'b1;
      tick();
      tick();
      we = 1'b0;
      check("tx during reset", {31'd0, tx}, 32'd1);
      statusNow(st);
      check("status during reset", st, 32'h2);
      reset = 1'b0;
      statusNow(st);
      check("status after reset", st, 32'h2);
      repeat (3) tick();
      statusNow(st);
      check("store under reset dropped", st, 32'h2);
      check("tx idle after reset", {31'd0, tx}, 32'd1);

      // Register decode table.
      for (int i = 0; i < 12; i++) begin
         dataAddr  = vecs[i].addr;
         we        = vecs[i].we;
         writeData = vecs[i].wd;
         #1;
         check($sformatf("vec%0d sel", i), {31'd0, sel}, {31'd0, vecs[i].expSel});
         check($sformatf("vec%0d readData", i), readData, vecs[i].expRd);
         tick();
         we = 1'b0;
      end

      // Single 0xA5 frame, checked cycle by cycle.
      frameByte = 8'hA5;
      for (int i = 0; i < 40; i++) begin
         if (i < 4) seq[i] = 1'b0;
         else if (i < 36) seq[i] = frameByte[(i - 4) / 4];
         else seq[i] = 1'b1;
      end
      expQ.push_back(frameByte);
      writeReg(BASE, {24'd0, frameByte});
      check("tx high on push edge", {31'd0, tx}, 32'd1);
      for (int i = 0; i < 40; i++) begin
         tick();
         check($sformatf("A5 tx cycle %0d", i), {31'd0, tx}, {31'd0, seq[i]});
         check($sformatf("A5 busy cycle %0d", i), {31'd0, readData[2]}, 32'd1);
      end
      tick();
      check("busy clear after frame", {31'd0, readData[2]}, 32'd0);
      waitIdle(200);

      // Five back-to-back stores while idle.
      startQ.delete();
      for (int b = 1; b <= 5; b++) begin
         dataAddr  = BASE;
         writeData = 32'(b);
         we        = 1'b1;
         tick();
         expQ.push_back(8'(b));
         if (b == 1) check("no pop on first push edge", {31'd0, tx}, 32'd1);
         if (b == 2) check("first pop on edge 2", {31'd0, tx}, 32'd0);
      end
      we = 1'b0;
      statusNow(st);
      check("status after five pushes", st, 32'h45);
      waitIdle(1000);
      check("five frames seen", startQ.size(), 32'd5);
      for (int j = 1; j < 5 && j < startQ.size(); j++)
         check($sformatf("frame gap %0d", j), startQ[j] - startQ[j - 1], 32'd41);

      // Overflow during a frame, then CTRL clear.
      expQ.push_back(8'h3C);
      writeReg(BASE, 32'h3C);
      tick();
      for (int b = 0; b < 6; b++) begin
         dataAddr  = BASE;
         writeData = 32'h60 + 32'(b);
         we        = 1'b1;
         tick();
         if (b < 4) expQ.push_back(8'h60 + 8'(b));
      end
      we = 1'b0;
      statusNow(st);
      check("status after overflow", st, 32'h4D);
      writeReg(BASE + 32'd8, 32'h0);
      statusNow(st);
      check("ctrl write 0 keeps overflow", st, 32'h4D);
      writeReg(BASE + 32'd8, 32'h1);
      statusNow(st);
      check("ctrl write 1 clears overflow", st, 32'h45);
      waitIdle(2000);

      // Reset in the middle of DATA bit 3 with two bytes queued.
      frameByte = 8'hC3;
      writeReg(BASE, {24'd0, frameByte});
      tick();
      writeReg(BASE, 32'h81);
      writeReg(BASE, 32'h82);
      repeat (14) tick();
      check("tx shows bit 3 before reset", {31'd0, tx}, {31'd0, frameByte[3]});
      reset     = 1'b1;
      dataAddr  = BASE;
      writeData = 32'h77;
      we        = 1'b1;
      tick();
      we = 1'b0;
      check("tx high after mid-frame reset", {31'd0, tx}, 32'd1);
      reset = 1'b0;
      expQ.delete();
      statusNow(st);
      check("status after mid-frame reset", st, 32'h2);
      lowCount = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (tx !== 1'b1) lowCount++;
      end
      check("no frames after reset", lowCount, 32'd0);
      statusNow(st);
      check("status stays idle", st, 32'h2);

      check("scoreboard drained", expQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
